lvalue_rmw_unit: RTL and testbench
==================================

Name: lvalue_rmw_unit

Overview:
- Parametrised read-modify-write engine over a small register file. Executes SystemVerilog-style compound assignments (=, +=, -=, *=, /=, %=, &=, |=, ^=, <<=, >>=, <<<=, >>>=, ++, --) on a whole word or on a bit-slice field.
- Successor to single-word lvalue handling: adds configurable width and depth, slice targets, pre/post values, multi-cycle divide and valid/ready handshakes.
- Used as the execution back end for lvalue lowering tests and simulation models.

Parameters:
WIDTH, 32, word width in bits (>=2)
DEPTH, 8, number of register-file entries (power of two, >=2)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  unit can accept request
req_op  in  4  opcode (see Behaviour)
req_addr  in  $clog2(DEPTH)  target entry
req_data  in  WIDTH  right-hand operand / shift amount
req_lsb  in  $clog2(WIDTH)  slice low bit
req_len  in  $clog2(WIDTH)+1  slice length; 0 means full word
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_old  out  WIDTH  field value before the op (post-inc/dec result), zero-extended
rsp_new  out  WIDTH  field value after the op (pre-inc/dec result), zero-extended
rsp_err  out  1  illegal slice or divide/modulo by zero

Behaviour:
- Reset: regfile entries=0, state=IDLE, req_ready=0 during reset then 1, rsp_valid=0, rsp_old=rsp_new=0, rsp_err=0. Reset mid-operation discards the in-flight op with no write-back.
- Opcodes: 0 SET, 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 MOD, 6 AND, 7 OR, 8 XOR, 9 SHL, 10 SHR, 11 ASHL, 12 ASHR, 13 INC, 14 DEC, 15 READ (no write).
- Field: L = req_len (WIDTH if 0), F = reg[req_lsb +: L]. req_data is truncated to L bits. The result is truncated to L bits and written back; bits outside the field are unchanged.
- Illegal slice: req_lsb+L > WIDTH -> rsp_err=1, no write, rsp_old=rsp_new=0.
- Arithmetic: ADD/SUB/MUL/INC/DEC are modulo 2^L.
- Signedness: DIV, MOD and ASHR treat F and the operand as signed L-bit values. DIV truncates toward zero; MOD takes the sign of the dividend.
- Division overflow: most-negative / -1 gives quotient = most-negative, remainder = 0.
- Divide/modulo by zero: rsp_err=1, no write, rsp_new=rsp_old.
- Shifts: amount = full req_data (unsigned). Amount >= L gives 0 for SHL/SHR/ASHL, and all-sign-bits for ASHR. ASHL is identical to SHL.
- FSM IDLE -> EXEC -> (DIV) -> RESP -> IDLE:
  - IDLE: req_ready=1. A request is accepted on req_valid&&req_ready and its fields are latched.
  - EXEC: one cycle; reads F and computes the result. Non-divide ops write back at the end of EXEC.
  - DIV: iterative restoring divider, exactly L cycles; writes back on the last cycle.
  - RESP: rsp_valid=1; outputs held stable until rsp_ready. Leaves for IDLE on the handshake cycle.
- Latency (rsp_ready held 1): non-divide ops accepted at edge t -> rsp_valid at t+2. DIV/MOD -> rsp_valid at t+2+L.
- One op outstanding at a time. req_ready=0 outside IDLE, so back-to-back ops to the same address are naturally ordered.
- A response stalled in RESP blocks new requests; the register file is already updated.

Test Plan:
- Reset, then READ each addr 0..7 -> rsp_old=rsp_new=0, rsp_err=0; assert rst during a DIV -> no write, rsp_valid=0 next cycle.
- SET addr2=0xFFFF_FFFF, then ADD 1 -> rsp_old=0xFFFF_FFFF, rsp_new=0 (wrap); then INC -> old=0, new=1, valid 2 cycles after accept.
- Slice: SET addr1=0, then SET lsb=4 len=8 data=0x1A5 -> addr1 reads 0x0000_0A50, rsp_new=0xA5; then lsb=28 len=8 -> rsp_err=1, addr1 unchanged.
- DIV addr3=-7 by 2 -> new=-3 (0xFFFF_FFFD); MOD -7 by 2 -> -1; DIV 0x8000_0000 by -1 -> 0x8000_0000; DIV by 0 -> err=1, value unchanged; latency 34 cycles.
- Shifts on 0x8000_0001: SHR 1 -> 0x4000_0000; ASHR 1 -> 0xC000_0000; ASHR 40 -> 0xFFFF_FFFF; SHL 32 -> 0.
- Backpressure: hold rsp_ready=0 for 5 cycles with req_valid=1 -> req_ready stays 0, rsp outputs stable, second op accepted the cycle after the handshake.

Source files
------------

// File: rtl/lvalue_rmw_unit.sv
// Read-modify-write engine: applies compound assignments to a whole register-file word
// or to a bit-slice field of it, with an iterative signed divider for DIV/MOD.
module lvalue_rmw_unit #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [3:0]                 req_op,
   input  logic [$clog2(DEPTH)-1:0]   req_addr,
   input  logic [WIDTH-1:0]           req_data,
   input  logic [$clog2(WIDTH)-1:0]   req_lsb,
   input  logic [$clog2(WIDTH):0]     req_len,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [WIDTH-1:0]           rsp_old,
   output logic [WIDTH-1:0]           rsp_new,
   output logic                       rsp_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(WIDTH);

   localparam logic [3:0] OP_SET  = 4'd0,  OP_ADD  = 4'd1,  OP_SUB  = 4'd2,  OP_MUL  = 4'd3;
   localparam logic [3:0] OP_DIV  = 4'd4,  OP_MOD  = 4'd5,  OP_AND  = 4'd6,  OP_OR   = 4'd7;
   localparam logic [3:0] OP_XOR  = 4'd8,  OP_SHL  = 4'd9,  OP_SHR  = 4'd10, OP_ASHL = 4'd11;
   localparam logic [3:0] OP_ASHR = 4'd12, OP_INC  = 4'd13, OP_DEC  = 4'd14, OP_READ = 4'd15;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV, S_RESP} state_t;

   typedef struct packed {
      logic [3:0]       op;
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] data;
      logic [LW-1:0]    lsb;
      logic [LW:0]      len;
   } req_t;

   state_t           state, state_nx;
   req_t             rq;
   logic [WIDTH-1:0] regs [DEPTH];

   // field decode, all from the latched request
   logic [LW:0]      fl;
   logic [LW+1:0]    fend;
   logic             illegal, is_div, div_zero, shift_big;
   logic [WIDTH-1:0] mask, topbit, word, f, opnd, f_sx, op_sx, res, res_m;
   logic             f_neg, op_neg;

   assign fl        = (rq.len == '0) ? (LW+1)'(WIDTH) : rq.len;
   assign fend      = (LW+2)'(rq.lsb) + (LW+2)'(fl);
   assign illegal   = fend > (LW+2)'(WIDTH);
   assign mask      = ~({WIDTH{1'b1}} << fl);
   assign topbit    = mask ^ (mask >> 1);
   assign word      = regs[rq.addr];
   assign f         = (word >> rq.lsb) & mask;
   assign opnd      = rq.data & mask;
   assign f_neg     = |(f & topbit);
   assign op_neg    = |(opnd & topbit);
   assign f_sx      = f_neg ? (f | ~mask) : f;
   assign op_sx     = op_neg ? (opnd | ~mask) : opnd;
   assign shift_big = rq.data >= WIDTH'(fl);
   assign is_div    = (rq.op == OP_DIV) || (rq.op == OP_MOD);
   assign div_zero  = (opnd == '0);

   always_comb begin
      res = f;
      case (rq.op)
         OP_SET:           res = opnd;
         OP_ADD:           res = f + opnd;
         OP_SUB:           res = f - opnd;
         OP_MUL:           res = f * opnd;
         OP_AND:           res = f & opnd;
         OP_OR:            res = f | opnd;
         OP_XOR:           res = f ^ opnd;
         OP_SHL, OP_ASHL:  res = shift_big ? '0 : (f << rq.data);
         OP_SHR:           res = shift_big ? '0 : (f >> rq.data);
         OP_ASHR:          res = shift_big ? (f_neg ? mask : '0) : WIDTH'($signed(f_sx) >>> rq.data);
         OP_INC:           res = f + WIDTH'(1);
         OP_DEC:           res = f - WIDTH'(1);
         default:          res = f;
      endcase
   end
   assign res_m = res & mask;

   // restoring divider on magnitudes; dividend is pre-aligned so its field MSB sits at the top
   logic [WIDTH-1:0] dvd, quo, rem, div_b, abs_a, abs_b, rem_nx, quo_nx, div_res;
   logic [WIDTH:0]   rem_sh;
   logic [LW:0]      cnt;
   logic             q_neg, r_neg, ge, div_last;

   assign abs_a    = f_neg ? -f_sx : f_sx;
   assign abs_b    = op_neg ? -op_sx : op_sx;
   assign rem_sh   = {rem, dvd[WIDTH-1]};
   assign ge       = rem_sh >= {1'b0, div_b};
   assign rem_nx   = ge ? WIDTH'(rem_sh - {1'b0, div_b}) : rem_sh[WIDTH-1:0];
   assign quo_nx   = {quo[WIDTH-2:0], ge};
   assign div_last = (cnt == (LW+1)'(1));
   assign div_res  = ((rq.op == OP_DIV) ? (q_neg ? -quo_nx : quo_nx)
                                        : (r_neg ? -rem_nx : rem_nx)) & mask;

   function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] w, v, m,
                                              input logic [LW-1:0] lsb);
      return (w & ~(m << lsb)) | ((v & m) << lsb);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (req_valid) state_nx = S_EXEC;
         S_EXEC: state_nx = (!illegal && is_div && !div_zero) ? S_DIV : S_RESP;
         S_DIV:  if (div_last) state_nx = S_RESP;
         S_RESP: if (rsp_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == S_IDLE) && !rst;
      rsp_valid = (state == S_RESP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         rq      <= '0;
         rsp_old <= '0;
         rsp_new <= '0;
         rsp_err <= 1'b0;
         dvd     <= '0;
         quo     <= '0;
         rem     <= '0;
         div_b   <= '0;
         cnt     <= '0;
         q_neg   <= 1'b0;
         r_neg   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (req_valid) begin
               rq.op   <= req_op;
               rq.addr <= req_addr;
               rq.data <= req_data;
               rq.lsb  <= req_lsb;
               rq.len  <= req_len;
            end
            S_EXEC: begin
               if (illegal) begin
                  rsp_err <= 1'b1;
                  rsp_old <= '0;
                  rsp_new <= '0;
               end else if (is_div) begin
                  rsp_old <= f;
                  rsp_new <= f;
                  rsp_err <= div_zero;
                  dvd     <= abs_a << (WIDTH - int'(fl));
                  div_b   <= abs_b;
                  quo     <= '0;
                  rem     <= '0;
                  cnt     <= fl;
                  q_neg   <= f_neg ^ op_neg;
                  r_neg   <= f_neg;
               end else begin
                  rsp_err <= 1'b0;
                  rsp_old <= f;
                  rsp_new <= res_m;
                  if (rq.op != OP_READ) regs[rq.addr] <= merge(word, res_m, mask, rq.lsb);
               end
            end
            S_DIV: begin
               dvd <= dvd << 1;
               quo <= quo_nx;
               rem <= rem_nx;
               cnt <= cnt - (LW+1)'(1);
               if (div_last) begin
                  regs[rq.addr] <= merge(word, div_res, mask, rq.lsb);
                  rsp_new       <= div_res;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lvalue_rmw_unit.sv
// Directed bench for lvalue_rmw_unit: word and slice ops, signed divide, shifts,
// backpressure and reset during a divide.
module tb_lvalue_rmw_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [3:0]  req_op;
   logic [2:0]  req_addr;
   logic [31:0] req_data;
   logic [4:0]  req_lsb;
   logic [5:0]  req_len;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_old, rsp_new;
   logic        rsp_err;

   int          n_asrt = 0;
   int          n_fail = 0;
   logic [31:0] r_old, r_new;
   logic        r_err;
   int          lat;

   localparam logic [3:0] SET = 0, ADD = 1, SUB = 2, MUL = 3, DIV = 4, MOD = 5, AND_ = 6, OR_ = 7;
   localparam logic [3:0] XOR_ = 8, SHL = 9, SHR = 10, ASHL = 11, ASHR = 12, INC = 13, DEC = 14, READ = 15;

   lvalue_rmw_unit #(.WIDTH(32), .DEPTH(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
      .req_data(req_data), .req_lsb(req_lsb), .req_len(req_len),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_old(rsp_old), .rsp_new(rsp_new), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [2:0] addr, input logic [31:0] data,
                        input logic [4:0] lsb, input logic [5:0] len);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_data = data; req_lsb = lsb; req_len = len;
   endtask

   // issue one op with rsp_ready high; lat = accept edge to the edge that first sees rsp_valid
   task automatic do_op(input logic [3:0] op, input logic [2:0] addr, input logic [31:0] data,
                        input logic [4:0] lsb, input logic [5:0] len);
      int cyc;
      @(negedge clk);
      drive(op, addr, data, lsb, len);
      cyc = 0;
      while (!req_ready && cyc < 50) begin @(negedge clk); cyc++; end
      chk("accept", {63'd0, req_ready}, 64'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      cyc = 1;
      @(negedge clk);
      while (!rsp_valid && cyc < 100) begin cyc++; @(negedge clk); end
      chk("rsp_seen", {63'd0, rsp_valid}, 64'd1);
      lat = cyc; r_old = rsp_old; r_new = rsp_new; r_err = rsp_err;
      @(posedge clk);
   endtask

   task automatic op_chk(input string tag, input logic [3:0] op, input logic [2:0] addr,
                         input logic [31:0] data, input logic [4:0] lsb, input logic [5:0] len,
                         input logic [31:0] e_old, input logic [31:0] e_new, input logic e_err);
      do_op(op, addr, data, lsb, len);
      chk({tag, ".old"}, {32'd0, r_old}, {32'd0, e_old});
      chk({tag, ".new"}, {32'd0, r_new}, {32'd0, e_new});
      chk({tag, ".err"}, {63'd0, r_err}, {63'd0, e_err});
   endtask

   initial begin
      rst = 1'b1; rsp_ready = 1'b1;
      req_valid = 1'b0; req_op = '0; req_addr = '0; req_data = '0; req_lsb = '0; req_len = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.req_ready", {63'd0, req_ready}, 64'd0);
      chk("rst.rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst.rsp", {rsp_new, rsp_old}, 64'd0);
      chk("rst.err", {63'd0, rsp_err}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle.req_ready", {63'd0, req_ready}, 64'd1);

      for (int a = 0; a < 8; a++) op_chk("rd_reset", READ, 3'(a), 32'h0, 5'd0, 6'd0, 32'h0, 32'h0, 1'b0);

      // whole-word wrap and increment
      op_chk("set2", SET, 3'd2, 32'hFFFF_FFFF, 5'd0, 6'd0, 32'h0, 32'hFFFF_FFFF, 1'b0);
      op_chk("add_wrap", ADD, 3'd2, 32'h1, 5'd0, 6'd0, 32'hFFFF_FFFF, 32'h0, 1'b0);
      op_chk("inc", INC, 3'd2, 32'h0, 5'd0, 6'd0, 32'h0, 32'h1, 1'b0);
      chk("inc.lat", 64'(lat), 64'd2);

      // slices
      op_chk("set1", SET, 3'd1, 32'h0, 5'd0, 6'd0, 32'h0, 32'h0, 1'b0);
      op_chk("set_slice", SET, 3'd1, 32'h1A5, 5'd4, 6'd8, 32'h0, 32'hA5, 1'b0);
      op_chk("rd_slice", READ, 3'd1, 32'h0, 5'd0, 6'd0, 32'h0000_0A50, 32'h0000_0A50, 1'b0);
      op_chk("bad_slice", SET, 3'd1, 32'hFF, 5'd28, 6'd8, 32'h0, 32'h0, 1'b1);
      op_chk("rd_after_bad", READ, 3'd1, 32'h0, 5'd0, 6'd0, 32'h0000_0A50, 32'h0000_0A50, 1'b0);
      op_chk("set4", SET, 3'd4, 32'hFFFF_FFFF, 5'd0, 6'd0, 32'h0, 32'hFFFF_FFFF, 1'b0);
      op_chk("add_slice", ADD, 3'd4, 32'h1, 5'd8, 6'd4, 32'hF, 32'h0, 1'b0);
      op_chk("rd4", READ, 3'd4, 32'h0, 5'd0, 6'd0, 32'hFFFF_F0FF, 32'hFFFF_F0FF, 1'b0);
      op_chk("set5", SET, 3'd5, 32'h9, 5'd0, 6'd4, 32'h0, 32'h9, 1'b0);
      op_chk("div_slice", DIV, 3'd5, 32'h2, 5'd0, 6'd4, 32'h9, 32'hD, 1'b0);
      chk("div_slice.lat", 64'(lat), 64'd6);
      op_chk("rd5", READ, 3'd5, 32'h0, 5'd0, 6'd0, 32'hD, 32'hD, 1'b0);

      // signed divide / modulo
      op_chk("set3", SET, 3'd3, 32'hFFFF_FFF9, 5'd0, 6'd0, 32'h0, 32'hFFFF_FFF9, 1'b0);
      op_chk("div_neg", DIV, 3'd3, 32'h2, 5'd0, 6'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 1'b0);
      chk("div.lat", 64'(lat), 64'd34);
      op_chk("set3b", SET, 3'd3, 32'hFFFF_FFF9, 5'd0, 6'd0, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 1'b0);
      op_chk("mod_neg", MOD, 3'd3, 32'h2, 5'd0, 6'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);
      op_chk("set3c", SET, 3'd3, 32'd100, 5'd0, 6'd0, 32'hFFFF_FFFF, 32'd100, 1'b0);
      op_chk("mod_negdiv", MOD, 3'd3, 32'hFFFF_FFF9, 5'd0, 6'd0, 32'd100, 32'd2, 1'b0);
      op_chk("set3d", SET, 3'd3, 32'd100, 5'd0, 6'd0, 32'd2, 32'd100, 1'b0);
      op_chk("div_negdiv", DIV, 3'd3, 32'hFFFF_FFF9, 5'd0, 6'd0, 32'd100, 32'hFFFF_FFF2, 1'b0);
      op_chk("set3e", SET, 3'd3, 32'h8000_0000, 5'd0, 6'd0, 32'hFFFF_FFF2, 32'h8000_0000, 1'b0);
      op_chk("div_ovf", DIV, 3'd3, 32'hFFFF_FFFF, 5'd0, 6'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
      op_chk("div_zero", DIV, 3'd3, 32'h0, 5'd0, 6'd0, 32'h8000_0000, 32'h8000_0000, 1'b1);
      op_chk("mod_zero", MOD, 3'd3, 32'h0, 5'd0, 6'd0, 32'h8000_0000, 32'h8000_0000, 1'b1);
      op_chk("rd3", READ, 3'd3, 32'h0, 5'd0, 6'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
      op_chk("mod_ovf", MOD, 3'd3, 32'hFFFF_FFFF, 5'd0, 6'd0, 32'h8000_0000, 32'h0, 1'b0);

      // shifts
      op_chk("set6", SET, 3'd6, 32'h8000_0001, 5'd0, 6'd0, 32'h0, 32'h8000_0001, 1'b0);
      op_chk("shr1", SHR, 3'd6, 32'd1, 5'd0, 6'd0, 32'h8000_0001, 32'h4000_0000, 1'b0);
      op_chk("set6b", SET, 3'd6, 32'h8000_0001, 5'd0, 6'd0, 32'h4000_0000, 32'h8000_0001, 1'b0);
      op_chk("ashr1", ASHR, 3'd6, 32'd1, 5'd0, 6'd0, 32'h8000_0001, 32'hC000_0000, 1'b0);
      op_chk("set6c", SET, 3'd6, 32'h8000_0001, 5'd0, 6'd0, 32'hC000_0000, 32'h8000_0001, 1'b0);
      op_chk("ashr40", ASHR, 3'd6, 32'd40, 5'd0, 6'd0, 32'h8000_0001, 32'hFFFF_FFFF, 1'b0);
      op_chk("set6d", SET, 3'd6, 32'h8000_0001, 5'd0, 6'd0, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
      op_chk("shl32", SHL, 3'd6, 32'd32, 5'd0, 6'd0, 32'h8000_0001, 32'h0, 1'b0);
      op_chk("set6e", SET, 3'd6, 32'h8000_0001, 5'd0, 6'd0, 32'h0, 32'h8000_0001, 1'b0);
      op_chk("ashl1", ASHL, 3'd6, 32'd1, 5'd0, 6'd0, 32'h8000_0001, 32'h0000_0002, 1'b0);

      // remaining ALU ops on addr0
      op_chk("sub", SUB, 3'd0, 32'h1, 5'd0, 6'd0, 32'h0, 32'hFFFF_FFFF, 1'b0);
      op_chk("dec", DEC, 3'd0, 32'h0, 5'd0, 6'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      op_chk("mul", MUL, 3'd0, 32'h3, 5'd0, 6'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFA, 1'b0);
      op_chk("and", AND_, 3'd0, 32'h0F0F_0F0F, 5'd0, 6'd0, 32'hFFFF_FFFA, 32'h0F0F_0F0A, 1'b0);
      op_chk("or", OR_, 3'd0, 32'h3000_0000, 5'd0, 6'd0, 32'h0F0F_0F0A, 32'h3F0F_0F0A, 1'b0);
      op_chk("xor", XOR_, 3'd0, 32'hFFFF_FFFF, 5'd0, 6'd0, 32'h3F0F_0F0A, 32'hC0F0_F0F5, 1'b0);
      op_chk("shr4", SHR, 3'd0, 32'd4, 5'd0, 6'd0, 32'hC0F0_F0F5, 32'h0C0F_0F0F, 1'b0);
      op_chk("shr32", SHR, 3'd0, 32'd32, 5'd0, 6'd0, 32'h0C0F_0F0F, 32'h0, 1'b0);
      op_chk("sub_slice", SUB, 3'd0, 32'h1, 5'd16, 6'd8, 32'h0, 32'hFF, 1'b0);
      op_chk("rd0", READ, 3'd0, 32'h0, 5'd0, 6'd0, 32'h00FF_0000, 32'h00FF_0000, 1'b0);

      // backpressure: response stalls, second request waits
      @(negedge clk);
      rsp_ready = 1'b0;
      drive(SET, 3'd0, 32'h1234, 5'd0, 6'd0);
      @(posedge clk);
      #1 drive(ADD, 3'd0, 32'h1, 5'd0, 6'd0);
      @(negedge clk);
      @(negedge clk);
      chk("bp.valid", {63'd0, rsp_valid}, 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp.req_ready", {63'd0, req_ready}, 64'd0);
         chk("bp.hold", {rsp_new, rsp_old}, {32'h1234, 32'h00FF_0000});
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp.idle_ready", {63'd0, req_ready}, 64'd1);
      chk("bp.idle_valid", {63'd0, rsp_valid}, 64'd0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("bp.exec_ready", {63'd0, req_ready}, 64'd0);
      @(negedge clk);
      chk("bp.second_valid", {63'd0, rsp_valid}, 64'd1);
      chk("bp.second", {rsp_new, rsp_old}, {32'h1235, 32'h1234});
      @(posedge clk);

      // reset in the middle of a divide
      op_chk("set7", SET, 3'd7, 32'd100, 5'd0, 6'd0, 32'h0, 32'd100, 1'b0);
      @(negedge clk);
      drive(DIV, 3'd7, 32'd3, 5'd0, 6'd0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rstdiv.valid", {63'd0, rsp_valid}, 64'd0);
      chk("rstdiv.req_ready", {63'd0, req_ready}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rstdiv.idle", {63'd0, req_ready}, 64'd1);
      op_chk("rd7_after_rst", READ, 3'd7, 32'h0, 5'd0, 6'd0, 32'h0, 32'h0, 1'b0);
      op_chk("rd2_after_rst", READ, 3'd2, 32'h0, 5'd0, 6'd0, 32'h0, 32'h0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
